multicycle_controller: RTL and testbench

//  Control FSM for the multicycle RV32 datapath, directly upstream of alu. Decodes the

---
 rtl/multicycle_controller_pkg.sv | 81 ++++++++
 rtl/multicycle_controller_if.sv | 40 ++++
 rtl/multicycle_controller_alu_decoder.sv | 42 ++++
 rtl/multicycle_controller.sv | 172 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32 control path:
// opcodes, ALU/mux selects, FSM states and branch resolution.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JALRADR,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Returns {valid, taken}; flags come from rs1 - rs2.
  function automatic logic [1:0] branch_eval(
    input logic [2:0] funct3,
    input logic       zero,
    input logic       n,
    input logic       v
  );
    logic [1:0] r;
    r = 2'b00;
    case (funct3)
      3'b000:  r = {1'b1, zero};
      3'b001:  r = {1'b1, ~zero};
      3'b100:  r = {1'b1, n ^ v};
      3'b101:  r = {1'b1, ~(n ^ v)};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: decoded instruction
// fields and flags in, mux selects and enables out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       N;
  logic       V;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5,
    input  Zero, N, V, MemReady,
    output PCWrite, AdrSrc, MemWrite,
    output IRWrite, RegWrite, ResultSrc,
    output ALUSrcA, ALUSrcB, ImmSrc,
    output ALUControl, Illegal
  );

  modport slave (
    output op, funct3, funct7b5,
    output Zero, N, V, MemReady,
    input  PCWrite, AdrSrc, MemWrite,
    input  IRWrite, RegWrite, ResultSrc,
    input  ALUSrcA, ALUSrcB, ImmSrc,
    input  ALUControl, Illegal
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps ALUOp plus funct fields onto the alu operation,
// flagging R/I encodings this datapath cannot execute.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       illegal_funct
);

  always_comb begin
    alu_control   = ALU_ADD;
    illegal_funct = 1'b0;
    unique case (1'b1)
      (alu_op == ALUOP_SUB): alu_control = ALU_SUB;
      (alu_op == ALUOP_FUNCT): begin
        case (funct3)
          3'b000: alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b100: alu_control = ALU_XOR;
          // sra/srai have no alu support
          3'b101: begin
            alu_control   = ALU_SRL;
            illegal_funct = funct7b5;
          end
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
          default: begin
            alu_control   = ALU_ADD;
            illegal_funct = 1'b1;
          end
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM: sequences fetch, decode,
// execute, memory and writeback over 3-5 states.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter bit SUPPORT_LUI     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  multicycle_controller_if.master bus
);

  state_t     state;
  state_t     cur;
  logic [1:0] alu_op;
  logic [2:0] alu_control;
  logic       illegal_funct;
  logic [1:0] br;
  logic       is_lui;

  logic       pc_w;
  logic       adr;
  logic       mem_w;
  logic       ir_w;
  logic       reg_w;
  logic [1:0] res;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [2:0] imm;
  logic       ill;

  assign cur    = reset ? S_FETCH : state;
  assign br     = branch_eval(bus.funct3, bus.Zero, bus.N, bus.V);
  assign is_lui = (bus.op == OP_LUI);

  alu_decoder u_alu_dec (
    .alu_op        (alu_op),
    .op5           (bus.op[5]),
    .funct3        (bus.funct3),
    .funct7b5      (bus.funct7b5),
    .alu_control   (alu_control),
    .illegal_funct (illegal_funct)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:
          if (bus.MemReady) state <= S_DECODE;
        S_DECODE:
          case (bus.op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_R:              state <= S_EXECR;
            OP_IMM:            state <= S_EXECI;
            OP_LUI:
              state <= SUPPORT_LUI ? S_EXECI : S_TRAP;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALRADR;
            default:           state <= S_TRAP;
          endcase
        S_MEMADR:
          state <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:
          if (bus.MemReady) state <= S_MEMWB;
        S_MEMWRITE:
          if (bus.MemReady) state <= S_FETCH;
        S_MEMWB:
          state <= S_FETCH;
        S_EXECR, S_EXECI:
          state <= illegal_funct ? S_TRAP : S_ALUWB;
        S_ALUWB:
          state <= S_FETCH;
        S_BRANCH:
          state <= br[1] ? S_FETCH : S_TRAP;
        S_JALRADR:
          state <= S_JAL;
        S_JAL:
          state <= S_ALUWB;
        S_TRAP:
          state <= HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
        default:
          state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_w   = 1'b0;
    adr    = 1'b0;
    mem_w  = 1'b0;
    ir_w   = 1'b0;
    reg_w  = 1'b0;
    res    = RES_ALUOUT;
    src_a  = SRCA_PC;
    src_b  = SRCB_RD2;
    imm    = IMM_I;
    alu_op = ALUOP_ADD;
    ill    = 1'b0;
    case (cur)
      S_FETCH: begin
        src_b = SRCB_FOUR;
        res   = RES_ALURES;
        pc_w  = bus.MemReady;
        ir_w  = bus.MemReady;
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        imm   = IMM_B;
      end
      S_MEMADR: begin
        src_a = SRCA_RD1;
        src_b = SRCB_IMM;
        imm   = bus.op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: adr = 1'b1;
      S_MEMWRITE: begin
        adr   = 1'b1;
        mem_w = 1'b1;
      end
      S_MEMWB: begin
        res   = RES_DATA;
        reg_w = 1'b1;
      end
      S_EXECR: begin
        src_a  = SRCA_RD1;
        alu_op = ALUOP_FUNCT;
      end
      // lui rides the I path as 0 + immU
      S_EXECI: begin
        src_a  = is_lui ? SRCA_ZERO : SRCA_RD1;
        src_b  = SRCB_IMM;
        imm    = is_lui ? IMM_U : IMM_I;
        alu_op = is_lui ? ALUOP_ADD : ALUOP_FUNCT;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        src_a  = SRCA_RD1;
        alu_op = ALUOP_SUB;
        pc_w   = br[1] & br[0];
      end
      S_JALRADR: begin
        src_a = SRCA_RD1;
        src_b = SRCB_IMM;
      end
      S_JAL: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_FOUR;
        pc_w  = 1'b1;
      end
      S_TRAP: ill = 1'b1;
      default: ;
    endcase
  end

  assign bus.PCWrite    = pc_w & ~reset;
  assign bus.IRWrite    = ir_w & ~reset;
  assign bus.MemWrite   = mem_w & ~reset;
  assign bus.RegWrite   = reg_w & ~reset;
  assign bus.Illegal    = ill & ~reset;
  assign bus.AdrSrc     = adr;
  assign bus.ResultSrc  = res;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ImmSrc     = imm;
  assign bus.ALUControl = alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle bench for the multicycle
// controller, halting and non-halting trap variants.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_a;
  logic       rst_b;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7;
  logic       zf;
  logic       nf;
  logic       vf;
  logic       mrdy;
  int         total;
  int         bad;

  multicycle_controller_if ia ();
  multicycle_controller_if ib ();

  assign ia.op       = op;
  assign ia.funct3   = f3;
  assign ia.funct7b5 = f7;
  assign ia.Zero     = zf;
  assign ia.N        = nf;
  assign ia.V        = vf;
  assign ia.MemReady = mrdy;
  assign ib.op       = op;
  assign ib.funct3   = f3;
  assign ib.funct7b5 = f7;
  assign ib.Zero     = zf;
  assign ib.N        = nf;
  assign ib.V        = vf;
  assign ib.MemReady = mrdy;

  multicycle_controller #(
    .HALT_ON_ILLEGAL (1'b1),
    .SUPPORT_LUI     (1'b1)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ia)
  );

  multicycle_controller #(
    .HALT_ON_ILLEGAL (1'b0),
    .SUPPORT_LUI     (1'b1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ib)
  );

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,
  //  ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Illegal}
  logic [17:0] va;
  logic [17:0] vb;
  assign va = {ia.PCWrite, ia.AdrSrc, ia.MemWrite,
               ia.IRWrite, ia.RegWrite, ia.ResultSrc,
               ia.ALUSrcA, ia.ALUSrcB, ia.ImmSrc,
               ia.ALUControl, ia.Illegal};
  assign vb = {ib.PCWrite, ib.AdrSrc, ib.MemWrite,
               ib.IRWrite, ib.RegWrite, ib.ResultSrc,
               ib.ALUSrcA, ib.ALUSrcB, ib.ImmSrc,
               ib.ALUControl, ib.Illegal};

  localparam logic [17:0] FETCH_R =
    {5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0};
  localparam logic [17:0] FETCH_W =
    {5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0};
  localparam logic [17:0] DECODE =
    {5'b00000, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 1'b0};
  localparam logic [17:0] MEMADR_LW =
    {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0};
  localparam logic [17:0] MEMADR_SW =
    {5'b00000, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 1'b0};
  localparam logic [17:0] MEMREAD =
    {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
  localparam logic [17:0] MEMWRITE =
    {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
  localparam logic [17:0] MEMWB =
    {5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
  localparam logic [17:0] EXECR_ADD =
    {5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 1'b0};
  localparam logic [17:0] EXECR_SUB =
    {5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 1'b0};
  localparam logic [17:0] EXECI_AND =
    {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b010, 1'b0};
  localparam logic [17:0] EXECI_LUI =
    {5'b00000, 2'b00, 2'b11, 2'b01, 3'b100, 3'b000, 1'b0};
  localparam logic [17:0] ALUWB =
    {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
  localparam logic [17:0] BR_T =
    {5'b10000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 1'b0};
  localparam logic [17:0] BR_N =
    {5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 1'b0};
  localparam logic [17:0] JAL =
    {5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0};
  localparam logic [17:0] TRAP =
    {5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ca(input string tag, input logic [17:0] e);
    #1;
    chk(tag, 32'(va), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic cb(input string tag, input logic [17:0] e);
    #1;
    chk(tag, 32'(vb), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic ins(
    input logic [6:0] o,
    input logic [2:0] fn3,
    input logic       fn7
  );
    op = o;
    f3 = fn3;
    f7 = fn7;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    op    = 7'd0;
    f3    = 3'd0;
    f7    = 1'b0;
    zf    = 1'b0;
    nf    = 1'b0;
    vf    = 1'b0;
    mrdy  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ca("reset_outs", FETCH_W);
    rst_a = 1'b0;

    // lw interrupted by reset while waiting in MEMREAD
    ins(7'b0000011, 3'b010, 1'b0);
    ca("lw0_fetch", FETCH_R);
    ca("lw0_decode", DECODE);
    ca("lw0_memadr", MEMADR_LW);
    mrdy = 1'b0;
    ca("lw0_memread", MEMREAD);
    rst_a = 1'b1;
    ca("rst_mid_outs", FETCH_W);
    rst_a = 1'b0;
    ca("rst_to_fetch", FETCH_W);
    mrdy = 1'b1;

    ins(7'b0110011, 3'b000, 1'b0);
    ca("add_fetch", FETCH_R);
    ca("add_decode", DECODE);
    ca("add_execr", EXECR_ADD);
    ca("add_aluwb", ALUWB);

    ins(7'b0110011, 3'b000, 1'b1);
    ca("sub_fetch", FETCH_R);
    ca("sub_decode", DECODE);
    ca("sub_execr", EXECR_SUB);
    ca("sub_aluwb", ALUWB);

    ins(7'b0000011, 3'b010, 1'b0);
    ca("lw_fetch", FETCH_R);
    ca("lw_decode", DECODE);
    ca("lw_memadr", MEMADR_LW);
    mrdy = 1'b0;
    for (int i = 0; i < 3; i++) ca("lw_memread_wait", MEMREAD);
    mrdy = 1'b1;
    ca("lw_memread_done", MEMREAD);
    ca("lw_memwb", MEMWB);

    ins(7'b0100011, 3'b010, 1'b0);
    ca("sw_fetch", FETCH_R);
    ca("sw_decode", DECODE);
    ca("sw_memadr", MEMADR_SW);
    ca("sw_memwrite", MEMWRITE);

    ins(7'b1100011, 3'b000, 1'b0);
    zf = 1'b1;
    ca("beq_fetch", FETCH_R);
    ca("beq_decode", DECODE);
    ca("beq_taken", BR_T);

    ins(7'b1100011, 3'b101, 1'b0);
    zf = 1'b0;
    nf = 1'b1;
    vf = 1'b1;
    ca("bge_fetch", FETCH_R);
    ca("bge_decode", DECODE);
    ca("bge_taken", BR_T);

    ins(7'b1100011, 3'b100, 1'b0);
    vf = 1'b0;
    ca("blt_fetch", FETCH_R);
    ca("blt_decode", DECODE);
    ca("blt_taken", BR_T);

    ins(7'b1100011, 3'b001, 1'b0);
    zf = 1'b1;
    nf = 1'b0;
    ca("bne_fetch", FETCH_R);
    ca("bne_decode", DECODE);
    ca("bne_not_taken", BR_N);
    zf = 1'b0;

    ins(7'b1100111, 3'b000, 1'b0);
    ca("jalr_fetch", FETCH_R);
    ca("jalr_decode", DECODE);
    ca("jalr_adr", MEMADR_LW);
    ca("jalr_jal", JAL);
    ca("jalr_aluwb", ALUWB);

    ins(7'b1101111, 3'b000, 1'b0);
    ca("jal_fetch", FETCH_R);
    ca("jal_decode", DECODE);
    ca("jal_jal", JAL);
    ca("jal_aluwb", ALUWB);

    ins(7'b0110111, 3'b101, 1'b1);
    ca("lui_fetch", FETCH_R);
    ca("lui_decode", DECODE);
    ca("lui_execi", EXECI_LUI);
    ca("lui_aluwb", ALUWB);

    ins(7'b0010011, 3'b111, 1'b0);
    ca("andi_fetch", FETCH_R);
    ca("andi_decode", DECODE);
    ca("andi_execi", EXECI_AND);
    ca("andi_aluwb", ALUWB);

    ins(7'b0110011, 3'b011, 1'b0);
    ca("ill_fetch", FETCH_R);
    ca("ill_decode", DECODE);
    ca("ill_execr", EXECR_ADD);
    for (int i = 0; i < 10; i++) ca("ill_trap_hold", TRAP);
    rst_a = 1'b1;
    ca("ill_reset_outs", FETCH_W);
    rst_a = 1'b0;
    ca("ill_after_reset", FETCH_R);

    // non-halting variant: one-cycle Illegal pulse
    rst_a = 1'b1;
    rst_b = 1'b0;
    ins(7'b0110011, 3'b011, 1'b0);
    cb("p_fetch", FETCH_R);
    cb("p_decode", DECODE);
    cb("p_execr", EXECR_ADD);
    cb("p_trap", TRAP);
    ins(7'b1111111, 3'b000, 1'b0);
    cb("p_refetch", FETCH_R);
    cb("badop_decode", DECODE);
    cb("badop_trap", TRAP);
    ins(7'b1100011, 3'b010, 1'b0);
    cb("badbr_fetch", FETCH_R);
    cb("badbr_decode", DECODE);
    cb("badbr_branch", BR_N);
    cb("badbr_trap", TRAP);
    cb("badbr_refetch", FETCH_R);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
